// File: rtl/store.sv
// store: AXI4 single-beat write master; latches one word + address per request, reports done/err/count.
// Latency: AW/W issue on the acceptance edge; O_DONE pulses the cycle after the B handshake (>= 2 cycles).
// Backpressure: MEM_WAIT high from acceptance until B completes; READY may stall indefinitely, VALID holds.
// Optional feature: define STORE_RESP_CHECK_EN to latch non-OKAY BRESP into the sticky O_ERR flag.
module store #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_AWUSER_WIDTH    = 1,
  parameter int C_M_AXI_WUSER_WIDTH     = 4,
  parameter int C_M_AXI_BUSER_WIDTH     = 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  output logic                               MEM_WAIT,
  input  logic                               I_VALID,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]      I_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      I_DATA,
  output logic                               O_DONE,
  output logic                               O_ERR,
  output logic [15:0]                        O_COUNT,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic                               M_AXI_AWLOCK,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic [2:0]                         M_AXI_AWPROT,
  output logic [3:0]                         M_AXI_AWQOS,
  output logic [C_M_AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic [C_M_AXI_WUSER_WIDTH-1:0]     M_AXI_WUSER,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic [C_M_AXI_BUSER_WIDTH-1:0]     M_AXI_BUSER,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;

  state_t                          state, state_nxt;
  logic                            aw_done, w_done;
  logic                            aw_vld, w_vld, b_rdy;
  logic                            accept, b_hs;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                            done_q;
  logic [15:0]                     count_q;
  logic                            unused_sig;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and channel handshake signals; VALIDs depend only on state and done flags.
  always_comb begin
    state_nxt = state;
    aw_vld    = 1'b0;
    w_vld     = 1'b0;
    b_rdy     = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (I_VALID) begin
          accept    = 1'b1;
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        aw_vld = !aw_done;
        w_vld  = !w_done;
        // A handshake completing on this edge counts as done.
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
          state_nxt = S_RESP;
      end
      S_RESP: begin
        b_rdy = 1'b1;
        if (M_AXI_BVALID) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign b_hs = b_rdy && M_AXI_BVALID;

  // Track AW and W completion independently; cleared on each new request.
  always_ff @(posedge CLK) begin
    if (RST || accept) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_vld && M_AXI_AWREADY) aw_done <= 1'b1;
      if (w_vld && M_AXI_WREADY)   w_done  <= 1'b1;
    end
  end

  // Capture address (word-aligned) and data at acceptance; held until the next request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      awaddr_q <= {I_ADDR[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
      wdata_q  <= I_DATA;
    end
  end

  // Completion pulse and wrapping write counter, both driven by the B handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      done_q <= b_hs;
      if (b_hs) count_q <= count_q + 16'd1;
    end
  end

`ifdef STORE_RESP_CHECK_EN
  logic err_q;

  // Sticky error on any non-OKAY write response.
  always_ff @(posedge CLK) begin
    if (RST)                                err_q <= 1'b0;
    else if (b_hs && M_AXI_BRESP != 2'b00)  err_q <= 1'b1;
  end

  assign O_ERR = err_q;
`else
  assign O_ERR = 1'b0;
`endif

  // BID/BUSER carry nothing this master needs; low address bits are forced to zero.
  assign unused_sig = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_BRESP, I_ADDR[1:0]};

  assign MEM_WAIT      = (state != S_IDLE);
  assign O_DONE        = done_q;
  assign O_COUNT       = count_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = aw_vld;

  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = w_vld;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_WVALID  = w_vld;

  assign M_AXI_BREADY  = b_rdy;

endmodule

// File: tb/tb_store.sv
// tb_store: directed checks of the store AXI write master.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// O_ERR expectation follows STORE_RESP_CHECK_EN.
module tb_store;
  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_WAIT;
  logic        I_VALID;
  logic [31:0] I_ADDR;
  logic [31:0] I_DATA;
  logic        O_DONE;
  logic        O_ERR;
  logic [15:0] O_COUNT;
  logic [0:0]  M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWLOCK;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_AWQOS;
  logic [0:0]  M_AXI_AWUSER;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic [3:0]  M_AXI_WUSER;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [0:0]  M_AXI_BID;
  logic [1:0]  M_AXI_BRESP;
  logic [0:0]  M_AXI_BUSER;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;
  int d0;
  logic exp_err;

  store dut (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT),
    .I_VALID(I_VALID), .I_ADDR(I_ADDR), .I_DATA(I_DATA),
    .O_DONE(O_DONE), .O_ERR(O_ERR), .O_COUNT(O_COUNT),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  always #5 CLK = ~CLK;

  // Count completion pulses, sampled mid-cycle.
  always @(negedge CLK) if (O_DONE === 1'b1) ndone++;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One write with immediate READY/BVALID; O_DONE must arrive 2 cycles after acceptance.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                          input string tag);
    int n;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = r;
    I_ADDR = a; I_DATA = d; I_VALID = 1'b1;
    step;
    I_VALID = 1'b0;
    n = 0;
    while (O_DONE !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    chk1({tag, " done"}, O_DONE, 1'b1);
    chk({tag, " latency"}, 32'(n), 32'd2);
    step;
    M_AXI_BRESP = 2'b00;
  endtask

  initial begin
`ifdef STORE_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    RST = 1'b1; I_VALID = 1'b0; I_ADDR = '0; I_DATA = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_BRESP = 2'b00; M_AXI_BID = '0; M_AXI_BUSER = '0;
    step; step;

    // Reset state and constant outputs
    chk1("rst mem_wait", MEM_WAIT, 1'b0);
    chk1("rst awvalid", M_AXI_AWVALID, 1'b0);
    chk1("rst wvalid", M_AXI_WVALID, 1'b0);
    chk1("rst wlast", M_AXI_WLAST, 1'b0);
    chk1("rst bready", M_AXI_BREADY, 1'b0);
    chk1("rst o_done", O_DONE, 1'b0);
    chk1("rst o_err", O_ERR, 1'b0);
    chk("rst o_count", {16'd0, O_COUNT}, 32'd0);
    chk("rst awaddr", M_AXI_AWADDR, 32'd0);
    chk("rst wdata", M_AXI_WDATA, 32'd0);
    chk("awsize", {29'd0, M_AXI_AWSIZE}, 32'd2);
    chk("awburst", {30'd0, M_AXI_AWBURST}, 32'd1);
    chk("awcache", {28'd0, M_AXI_AWCACHE}, 32'd3);
    chk("awlen", {24'd0, M_AXI_AWLEN}, 32'd0);
    chk("wstrb", {28'd0, M_AXI_WSTRB}, 32'hF);
    RST = 1'b0;
    step;

    // Single write, everything immediately ready
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1;
    I_ADDR = 32'h1000_0040; I_DATA = 32'hDEAD_BEEF; I_VALID = 1'b1;
    step;                                   // T0
    I_VALID = 1'b0;
    chk1("t0 mem_wait", MEM_WAIT, 1'b1);
    chk1("t0 awvalid", M_AXI_AWVALID, 1'b1);
    chk1("t0 wvalid", M_AXI_WVALID, 1'b1);
    chk1("t0 wlast", M_AXI_WLAST, 1'b1);
    chk1("t0 bready", M_AXI_BREADY, 1'b0);
    chk("t0 awaddr", M_AXI_AWADDR, 32'h1000_0040);
    chk("t0 wdata", M_AXI_WDATA, 32'hDEAD_BEEF);
    step;                                   // T1
    chk1("t1 bready", M_AXI_BREADY, 1'b1);
    chk1("t1 awvalid", M_AXI_AWVALID, 1'b0);
    chk1("t1 wvalid", M_AXI_WVALID, 1'b0);
    chk1("t1 o_done", O_DONE, 1'b0);
    step;                                   // T2
    chk1("t2 o_done", O_DONE, 1'b1);
    chk1("t2 mem_wait", MEM_WAIT, 1'b0);
    chk1("t2 bready", M_AXI_BREADY, 1'b0);
    chk("t2 o_count", {16'd0, O_COUNT}, 32'd1);
    step;                                   // T3
    chk1("t3 o_done", O_DONE, 1'b0);

    // Skewed: AWREADY delayed, WREADY immediate, unaligned address
    d0 = ndone;
    M_AXI_AWREADY = 1'b0;
    I_ADDR = 32'h2000_0013; I_DATA = 32'h0123_4567; I_VALID = 1'b1;
    step;                                   // T0
    I_VALID = 1'b0;
    chk("skew awaddr aligned", M_AXI_AWADDR, 32'h2000_0010);
    chk1("skew t0 awvalid", M_AXI_AWVALID, 1'b1);
    chk1("skew t0 wvalid", M_AXI_WVALID, 1'b1);
    step;                                   // T1
    chk1("skew t1 wvalid", M_AXI_WVALID, 1'b0);
    chk1("skew t1 awvalid", M_AXI_AWVALID, 1'b1);
    chk1("skew t1 bready", M_AXI_BREADY, 1'b0);
    for (int i = 0; i < 3; i++) begin       // T2..T4
      step;
      chk1("skew hold awvalid", M_AXI_AWVALID, 1'b1);
      chk1("skew hold bready", M_AXI_BREADY, 1'b0);
      chk1("skew hold wvalid", M_AXI_WVALID, 1'b0);
    end
    M_AXI_AWREADY = 1'b1;
    step;                                   // T5: AW handshake
    M_AXI_AWREADY = 1'b0;
    chk1("skew t5 awvalid", M_AXI_AWVALID, 1'b0);
    chk1("skew t5 bready", M_AXI_BREADY, 1'b1);
    step;                                   // T6
    chk1("skew o_done", O_DONE, 1'b1);
    chk("skew o_count", {16'd0, O_COUNT}, 32'd2);
    step; step;
    chk("skew one done", 32'(ndone - d0), 32'd1);

    // W after AW, late BVALID, request during busy ignored
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    I_ADDR = 32'h2000_0100; I_DATA = 32'hCAFE_0001; I_VALID = 1'b1;
    step;                                   // T0
    I_ADDR = 32'h3333_0000; I_DATA = 32'h5555_AAAA;
    step;                                   // T1
    chk1("rev awvalid", M_AXI_AWVALID, 1'b0);
    chk1("rev wvalid", M_AXI_WVALID, 1'b1);
    chk1("rev wlast", M_AXI_WLAST, 1'b1);
    chk("rev busy wdata", M_AXI_WDATA, 32'hCAFE_0001);
    chk("rev busy awaddr", M_AXI_AWADDR, 32'h2000_0100);
    M_AXI_WREADY = 1'b1;
    step;                                   // T2
    M_AXI_WREADY = 1'b0;
    chk1("rev bready", M_AXI_BREADY, 1'b1);
    chk1("rev wvalid done", M_AXI_WVALID, 1'b0);
    step;                                   // T3: no BVALID yet
    chk1("rev wait bready", M_AXI_BREADY, 1'b1);
    chk1("rev wait o_done", O_DONE, 1'b0);
    chk1("rev wait mem_wait", MEM_WAIT, 1'b1);
    I_VALID = 1'b0; M_AXI_BVALID = 1'b1;
    step;                                   // T4
    chk1("rev o_done", O_DONE, 1'b1);
    chk("rev o_count", {16'd0, O_COUNT}, 32'd3);
    chk("rev wdata kept", M_AXI_WDATA, 32'hCAFE_0001);
    step;

    // Back-to-back: I_VALID held for 10 cycles, accepts at 0,3,6,9
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1;
    d0 = ndone;
    for (int k = 0; k < 10; k++) begin
      I_VALID = 1'b1; I_DATA = 32'(k); I_ADDR = 32'h4000_0000 + 32'(4 * k);
      step;
      chk("b2b wdata", M_AXI_WDATA, 32'((k / 3) * 3));
      chk("b2b awaddr", M_AXI_AWADDR, 32'h4000_0000 + 32'(4 * ((k / 3) * 3)));
      chk1("b2b mem_wait", MEM_WAIT, (k % 3) != 2);
    end
    I_VALID = 1'b0;
    step; step; step;
    chk("b2b o_count", {16'd0, O_COUNT}, 32'd7);
    chk("b2b done pulses", 32'(ndone - d0), 32'd4);

    // Error response, then an OKAY write
    do_write(32'h5000_0000, 32'h0000_00E1, 2'b10, "err wr");
    chk1("err o_err", O_ERR, exp_err);
    do_write(32'h5000_0004, 32'h0000_00E2, 2'b00, "ok wr");
    chk1("err sticky", O_ERR, exp_err);
    chk("err o_count", {16'd0, O_COUNT}, 32'd9);

    // Counter wrap
    force dut.count_q = 16'hFFFF;
    step;
    release dut.count_q;
    step;
    do_write(32'h6000_0000, 32'h0000_FFFF, 2'b00, "wrap wr");
    chk("wrap o_count", {16'd0, O_COUNT}, 32'd0);

    // Reset in the middle of a transfer
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    I_ADDR = 32'h7000_0000; I_DATA = 32'h1234_5678; I_VALID = 1'b1;
    step;
    I_VALID = 1'b0;
    step;
    chk1("mid awvalid", M_AXI_AWVALID, 1'b1);
    RST = 1'b1;
    step;
    chk1("mid rst awvalid", M_AXI_AWVALID, 1'b0);
    chk1("mid rst wvalid", M_AXI_WVALID, 1'b0);
    chk1("mid rst bready", M_AXI_BREADY, 1'b0);
    chk1("mid rst mem_wait", MEM_WAIT, 1'b0);
    chk1("mid rst o_err", O_ERR, 1'b0);
    chk("mid rst o_count", {16'd0, O_COUNT}, 32'd0);
    chk("mid rst awaddr", M_AXI_AWADDR, 32'd0);
    RST = 1'b0;
    step;
    do_write(32'h7000_0010, 32'h8765_4321, 2'b00, "post rst wr");
    chk("post rst o_count", {16'd0, O_COUNT}, 32'd1);
    chk("post rst wdata", M_AXI_WDATA, 32'h8765_4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
